// File: rtl/sram_access_seq_if.sv
// Request/completion handshake between the control FSM (master) and the SRAM sequencer (slave).
interface sram_access_seq_if #(
    parameter int unsigned DATA_W = 16
);
    logic              Mem_OE;
    logic              Mem_WE;
    logic [15:0]       MAR;
    logic [DATA_W-1:0] MDR_in;
    logic [DATA_W-1:0] Read_data;
    logic              Ready;
    logic              Busy;

    modport master (
        output Mem_OE,
        output Mem_WE,
        output MAR,
        output MDR_in,
        input  Read_data,
        input  Ready,
        input  Busy
    );

    modport slave (
        input  Mem_OE,
        input  Mem_WE,
        input  MAR,
        input  MDR_in,
        output Read_data,
        output Ready,
        output Busy
    );
endinterface

// File: rtl/sram_access_seq.sv
// Turns Mem_OE / Mem_WE request levels into timed asynchronous-SRAM strobes, captures read data
// and returns a one-cycle Ready. Every output is a flop decoded from the next state.
module sram_access_seq #(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned READ_WAIT  = 2,
    parameter int unsigned WRITE_WAIT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_access_seq_if.slave  ctrl,
    input  logic [DATA_W-1:0] SRAM_DQ_in,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] SRAM_DQ_out,
    output logic              SRAM_DQ_oe,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    localparam logic [3:0] RdLoad = 4'(READ_WAIT - 1);
    localparam logic [3:0] WrLoad = 4'(WRITE_WAIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdDone,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StRelease
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d;
    logic              lb_n_q, lb_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    // Sequencing: acceptance, wait counting and read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            StIdle: begin
                // A simultaneous read request is dropped in favour of the write.
                if (ctrl.Mem_WE) begin
                    state_d = StWrSetup;
                    addr_d  = ADDR_W'(ctrl.MAR);
                    wdata_d = ctrl.MDR_in;
                end else if (ctrl.Mem_OE) begin
                    state_d = StRdWait;
                    addr_d  = ADDR_W'(ctrl.MAR);
                    cnt_d   = RdLoad;
                end
            end
            StRdWait: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = SRAM_DQ_in;
                    state_d = StRdDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRdDone: begin
                state_d = StRelease;
            end
            StWrSetup: begin
                cnt_d   = WrLoad;
                state_d = StWrPulse;
            end
            StWrPulse: begin
                if (cnt_q == 4'd0) begin
                    state_d = StWrHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrHold: begin
                state_d = StRelease;
            end
            StRelease: begin
                // Wait for both levels to drop so a held request is serviced only once.
                if (!ctrl.Mem_OE && !ctrl.Mem_WE) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes are decoded from the next state so they line up with the registered state.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        ready_d = 1'b0;
        busy_d  = (state_d != StIdle);

        case (state_d)
            StRdWait: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            StRdDone: begin
                ready_d = 1'b1;
            end
            StWrSetup: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            StWrPulse: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                we_n_d  = 1'b0;
            end
            StWrHold: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                ready_d = 1'b1;
            end
            default: begin
            end
        endcase

        ub_n_d = ce_n_d;
        lb_n_d = ce_n_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
            dq_oe_q <= dq_oe_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign SRAM_ADDR      = addr_q;
    assign SRAM_DQ_out    = wdata_q;
    assign SRAM_DQ_oe     = dq_oe_q;
    assign SRAM_CE_N      = ce_n_q;
    assign SRAM_OE_N      = oe_n_q;
    assign SRAM_WE_N      = we_n_q;
    assign SRAM_UB_N      = ub_n_q;
    assign SRAM_LB_N      = lb_n_q;
    assign ctrl.Read_data = rdata_q;
    assign ctrl.Ready     = ready_q;
    assign ctrl.Busy      = busy_q;

endmodule

// File: tb/tb_sram_access_seq.sv
// Randomised bench for sram_access_seq: a driver issues accesses and queues expectations,
// a monitor pops them on Ready, and a strobe watcher checks window lengths and exclusivity.
module tb_sram_access_seq;

    localparam int unsigned AddrW = 20;
    localparam int unsigned DataW = 16;
    localparam int unsigned Rw    = 2;
    localparam int unsigned Ww    = 2;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [31:0] issue;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [DataW-1:0] dq_in = '0;
    logic [AddrW-1:0] sram_addr;
    logic [DataW-1:0] dq_out;
    logic             dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

    sram_access_seq_if #(.DATA_W(DataW)) ctrl_if ();

    sram_access_seq #(
        .ADDR_W    (AddrW),
        .DATA_W    (DataW),
        .READ_WAIT (Rw),
        .WRITE_WAIT(Ww)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .ctrl       (ctrl_if),
        .SRAM_DQ_in (dq_in),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ_out(dq_out),
        .SRAM_DQ_oe (dq_oe),
        .SRAM_CE_N  (ce_n),
        .SRAM_OE_N  (oe_n),
        .SRAM_WE_N  (we_n),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] sram_mem [65536];
    logic [15:0] ref_mem [65536];
    logic [15:0] last_rd = '0;
    logic [15:0] cur_addr = '0;
    logic [15:0] cur_wdata = '0;
    bit          abort = 1'b0;
    int          n_issued = 0, n_reads = 0, n_writes = 0;
    int          n_ready = 0, n_oe_win = 0, n_we_win = 0;
    int          oe_len = 0, we_len = 0, dqoe_len = 0;
    int          ready_before;
    logic [15:0] pool [6] = '{16'h0042, 16'h1234, 16'hFFFF, 16'h0000, 16'h8001, 16'h00A5};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // SRAM pin model; DQ carries junk whenever the device is not driving a read.
    always @(negedge clk) begin
        if (ce_n === 1'b0 && we_n === 1'b0 && dq_oe === 1'b1) sram_mem[sram_addr[15:0]] = dq_out;
        if (ce_n === 1'b0 && oe_n === 1'b0) dq_in = sram_mem[sram_addr[15:0]];
        else dq_in = 16'($urandom);
    end

    // Strobe watcher.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("oe_dqoe_excl", 32'(oe_n === 1'b0 && dq_oe === 1'b1), 32'd0);
            if (ctrl_if.Ready === 1'b1) n_ready++;
            if (ce_n === 1'b0) begin
                check("ub_lb_active", 32'({ub_n, lb_n}), 32'd0);
                check("addr_stable", 32'(sram_addr), 32'(cur_addr));
            end else begin
                check("ub_lb_idle", 32'({ub_n, lb_n}), 32'd3);
            end
            if (dq_oe === 1'b1) check("dq_out_stable", 32'(dq_out), 32'(cur_wdata));
            if (oe_n === 1'b0) oe_len++;
            else if (oe_len > 0) begin
                if (!abort) check("oe_n_low_cycles", 32'(oe_len), 32'(Rw));
                n_oe_win++;
                oe_len = 0;
            end
            if (we_n === 1'b0) we_len++;
            else if (we_len > 0) begin
                if (!abort) check("we_n_low_cycles", 32'(we_len), 32'(Ww));
                n_we_win++;
                we_len = 0;
            end
            if (dq_oe === 1'b1) dqoe_len++;
            else if (dqoe_len > 0) begin
                if (!abort) check("dq_oe_cycles", 32'(dqoe_len), 32'(Ww + 2));
                dqoe_len = 0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (cyc > 0 && ctrl_if.Ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1, want ready=0 (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("ready_latency", 32'(cyc) - mon_e.issue,
                      mon_e.wr ? 32'(Ww + 2) : 32'(Rw + 1));
                check("sram_addr", 32'(sram_addr), 32'(mon_e.addr));
                if (mon_e.wr) begin
                    check("wr_dq_out", 32'(dq_out), 32'(mon_e.data));
                    check("wr_hold_strobes", 32'({dq_oe, ce_n, we_n, oe_n}), 32'b1011);
                    check("sram_readback", 32'(sram_mem[mon_e.addr]), 32'(mon_e.data));
                end else begin
                    check("read_data", 32'(ctrl_if.Read_data), 32'(mon_e.data));
                    check("rd_done_strobes", 32'({dq_oe, ce_n, we_n, oe_n}), 32'b0111);
                end
            end
        end
    end

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (ctrl_if.Busy === 1'b0) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%b, want busy=0 (cycle %0d)", ctrl_if.Busy, cyc);
        end
    endtask

    // kind: 0 read, 1 write, 2 both levels high (write expected). Called at a negedge while idle.
    task automatic do_txn(input int kind, input logic [15:0] addr, input logic [15:0] data,
                          input int hold);
        exp_t e;
        int   lat;
        e.wr    = (kind != 0);
        e.addr  = addr;
        e.data  = e.wr ? data : ref_mem[addr];
        e.issue = 32'(cyc);
        if (e.wr) begin
            ref_mem[addr] = data;
            n_writes++;
        end else begin
            last_rd = e.data;
            n_reads++;
        end
        n_issued++;
        cur_addr  = addr;
        cur_wdata = data;
        exp_q.push_back(e);
        ctrl_if.MAR    = addr;
        ctrl_if.MDR_in = data;
        ctrl_if.Mem_WE = (kind != 0);
        ctrl_if.Mem_OE = (kind != 1);
        @(negedge clk);
        for (int i = 1; i < hold; i++) begin
            ctrl_if.MAR    = 16'($urandom);
            ctrl_if.MDR_in = 16'($urandom);
            @(negedge clk);
        end
        lat = e.wr ? int'(Ww + 2) : int'(Rw + 1);
        if (hold >= lat + 2) check("held_req_busy", 32'(ctrl_if.Busy), 32'd1);
        ctrl_if.Mem_OE = 1'b0;
        ctrl_if.Mem_WE = 1'b0;
        wait_idle();
        check("read_data_held", 32'(ctrl_if.Read_data), 32'(last_rd));
    endtask

    initial begin
        rst            = 1'b1;
        ctrl_if.Mem_OE = 1'b1;
        ctrl_if.Mem_WE = 1'b0;
        ctrl_if.MAR    = 16'h0042;
        ctrl_if.MDR_in = 16'h0000;
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        sram_mem[16'h0042] = 16'hBEEF;
        ref_mem[16'h0042]  = 16'hBEEF;

        repeat (3) begin
            @(negedge clk);
            check("rst_strobes", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1F);
            check("rst_dq_oe", 32'(dq_oe), 32'd0);
            check("rst_ready_busy", 32'({ctrl_if.Ready, ctrl_if.Busy}), 32'd0);
            check("rst_read_data", 32'(ctrl_if.Read_data), 32'd0);
            check("rst_addr", 32'(sram_addr), 32'd0);
        end
        rst = 1'b0;

        do_txn(0, 16'h0042, 16'h0000, 10);
        do_txn(1, 16'h1234, 16'h5A5A, 1);
        do_txn(0, 16'h1234, 16'h0000, 2);
        do_txn(2, 16'h0042, 16'hC3C3, 3);
        do_txn(0, 16'h0042, 16'h0000, 12);

        for (int n = 0; n < 120; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_txn(int'($urandom_range(0, 2)), pool[$urandom_range(0, 5)], 16'($urandom),
                   int'($urandom_range(1, 12)));
        end

        repeat (2) @(negedge clk);
        check("ready_count", 32'(n_ready), 32'(n_issued));
        check("oe_windows", 32'(n_oe_win), 32'(n_reads));
        check("we_windows", 32'(n_we_win), 32'(n_writes));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // Reset during the second WE_N-low cycle of a write.
        abort          = 1'b1;
        ready_before   = n_ready;
        cur_addr       = 16'h0777;
        cur_wdata      = 16'h9C9C;
        ctrl_if.MAR    = 16'h0777;
        ctrl_if.MDR_in = 16'h9C9C;
        ctrl_if.Mem_WE = 1'b1;
        @(negedge clk);
        ctrl_if.Mem_WE = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_pulse", 32'(we_n), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_strobes", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1F);
        check("abort_dq_oe", 32'(dq_oe), 32'd0);
        check("abort_ready_busy", 32'({ctrl_if.Ready, ctrl_if.Busy}), 32'd0);
        check("abort_read_data", 32'(ctrl_if.Read_data), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_ready", 32'(n_ready), 32'(ready_before));
        check("abort_idle", 32'(ctrl_if.Busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
